sd_card_cmd_responder: RTL and testbench
========================================

Name: sd_card_cmd_responder

Overview:
- Synthesizable SD-card-side CMD-line responder for hardware-in-loop and regression benches of sd_host_controller.
- Decodes 48-bit host commands, checks CRC7, tracks a minimal identification-mode card state, and drives R1/R2/R3/R6/R7 responses with computed CRC7.
- Parametrised in identity (OCR/CID/RCA), busy polling count, NCR gap and response enable mask.
- Sits between the host cmd pin and an external tri-state buffer.

Parameters:
- RCA, 16'hF792, relative card address returned in R6.
- CID, 128'h7E4456BFAFE53C7AB12900000ECDB3, CID register; bits [7:1] hold the internal CRC, bit 0 is ignored and sent as 1.
- OCR, 32'h00FF8000, OCR without busy bit; bit 31 is forced by logic.
- BUSY_POLLS, 2, number of ACMD41 answered with OCR[31]=0 before reporting 1. Range 0..15.
- NCR, 2, SD clocks between the command end bit and the response start bit. Range 2..64.
- SYNC_STAGES, 2, synchronizer depth on sd_clk and cmd_in.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- sd_clk  in  1  host SD clock; synchronised and edge-detected internally; never used as a clock
- cmd_in  in  1  CMD line as seen by the card
- cmd_out  out  1  CMD drive value
- cmd_oe  out  1  CMD output enable
- card_state  out  4  0 idle, 1 ready, 2 ident, 3 stby
- cmd_valid  out  1  one-clk pulse when a command frame completes
- cmd_index  out  6  index of the last frame, held until the next frame
- crc_err  out  1  one-clk pulse on CRC7 or end-bit mismatch
- illegal_cmd  out  1  one-clk pulse on an unsupported index or wrong state

Behaviour:
- Reset values:
  - cmd_out=1, cmd_oe=0.
  - card_state=0, cmd_index=0, pulses=0.
  - app_cmd=0, busy counter=0, FSM=IDLE.
- Sampling:
  - cmd_in is sampled on each synchronised sd_clk rising edge (the "tick").
  - cmd_out changes only on the synchronised falling edge.
- FSM states and transitions:
  - IDLE: a 0 followed by a transmission bit of 1 goes to RX.
  - RX: shift 46 more bits, with CRC7 (x^7+x^3+1) running over bits 47..8. After the end bit, go to CHECK.
  - CHECK (one clk): pulse cmd_valid. Then one of:
    - CRC mismatch or end bit 0: pulse crc_err, go to IDLE, no response, no state change.
    - Otherwise decode and go to WAIT or IDLE.
  - WAIT: count NCR falling edges with cmd_oe=0, then go to TX.
  - TX: drive the response MSB-first with cmd_oe=1. CRC7 is generated on the fly over bits [47:8], or over CID[127:8] for R2 (the internal CID CRC is sent as-is). After the end bit, drive 1 for one more falling edge, release cmd_oe, go to IDLE.
- Decode (apply state transitions at CHECK):
  - CMD0: no response; card_state=idle, app_cmd=0, busy counter=0. Accepted in any state.
  - CMD8: R7 echoes arg[11:0] = {4'b0, VHS, check pattern}, CRC computed.
  - CMD55: R1; app_cmd=1 for the next frame only.
  - ACMD41 (index 41 with app_cmd set):
    - Response is R3 = {0, 0, 6'h3F, OCR with bit31, 7'h7F, 1}.
    - bit31 = (busy counter >= BUSY_POLLS); the counter increments and saturates at 15.
    - When bit31=1, card_state becomes ready.
  - CMD2 in ready: R2 136 bits = {0, 0, 6'h3F, CID[127:1], 1}; state becomes ident.
  - CMD3 in ident or stby: R6 = {0, 0, 6'd3, RCA, status16, crc, 1}; state becomes stby.
  - Anything else, or CMD2/CMD3 in the wrong state: pulse illegal_cmd, no response; app_cmd is still cleared.
- R1 card status:
  - Bits [12:9] carry card_state; bit 5 (APP_CMD) is set for the response to CMD55.
  - All other status bits are 0.
- R6 status16: {2'b0, 1'b0, card_state_at_cmd[3:0], 9'b0} with APP_CMD folded into bit 5.
- Frames during TX or WAIT:
  - A start bit on cmd_in while cmd_oe=1 is ignored (no collision detection).
  - After release, the decoder needs a fresh 1→0 after at least one idle 1.
- Asynchronous reset mid-frame or mid-TX: immediate release (cmd_oe=0) and all counters cleared.
- Boundary cases:
  - BUSY_POLLS=0: the first ACMD41 reports ready.
  - NCR is exact; a min/max is not implemented.

Decomposition:
- Package sd_card_pkg:
  - Card state encodings.
  - Response-type enum (NONE, R1, R2, R3, R6, R7).
  - Frame lengths 48/136.
  - Command index constants.
- Shared CRC7 serial function.
- Sub-module sd_crc7_serial: clear, enable and bit inputs, 7-bit output; one instance each for RX check and TX generate.

Test Plan:
- Host CMD0 frame 48'h40_00000000_95 -> no cmd_oe for 100 SD clocks; cmd_valid pulse; cmd_index=0; card_state=0.
- CMD8 frame 48'h48_000001AA_87 -> after exactly NCR=2 SD clocks, R7 48'h08_000001AA_xx with CRC matching the bench model; crc_err=0.
- CMD8 with a corrupted CRC byte 8'h86 -> crc_err pulse, no response, card_state unchanged.
- CMD55 then ACMD41, repeated 3 times with BUSY_POLLS=2:
  - OCR[31] must read 0, 0, 1.
  - card_state becomes 1 after the third.
  - R3 CRC field is 7'h7F.
- CMD2 then CMD3 from ready:
  - 136-bit R2 equal to {2'b00, 6'h3F, CID[127:1], 1}.
  - R6 carries RCA F792.
  - card_state goes 2 then 3.
- Ordering, reset and illegal cases:
  - CMD3 before CMD2 -> illegal_cmd, no response.
  - resetn low mid-R2 -> cmd_oe=0 within one clk; the next CMD0 is accepted normally.

Source files
------------

// File: rtl/sd_card_pkg.sv
// Shared types, frame constants and CRC7 step for the SD card CMD responder.
package sd_card_pkg;

   typedef enum logic [3:0] {
      CS_IDLE  = 4'd0,
      CS_READY = 4'd1,
      CS_IDENT = 4'd2,
      CS_STBY  = 4'd3
   } card_state_t;

   typedef enum logic [2:0] {
      RSP_NONE,
      RSP_R1,
      RSP_R2,
      RSP_R3,
      RSP_R6,
      RSP_R7
   } resp_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RX,
      ST_CHECK,
      ST_WAIT,
      ST_TX
   } fsm_t;

   localparam logic [7:0] LEN_SHORT = 8'd48;
   localparam logic [7:0] LEN_LONG  = 8'd136;

   localparam logic [5:0] CMD_GO_IDLE    = 6'd0;
   localparam logic [5:0] CMD_ALL_CID    = 6'd2;
   localparam logic [5:0] CMD_SEND_RCA   = 6'd3;
   localparam logic [5:0] CMD_IF_COND    = 6'd8;
   localparam logic [5:0] CMD_SD_OP_COND = 6'd41;
   localparam logic [5:0] CMD_APP        = 6'd55;

   // One LFSR step of x^7 + x^3 + 1, MSB-first data.
   function automatic logic [6:0] crc7_next(
      input logic [6:0] crc,
      input logic       din
   );
      logic fb;
      fb = din ^ crc[6];
      return {crc[5:3], crc[2] ^ fb, crc[1:0], fb};
   endfunction

endpackage

// File: rtl/sd_crc7_serial.sv
// Bit-serial CRC7 accumulator with synchronous clear.
module sd_crc7_serial
   import sd_card_pkg::*;
(
   input  logic       clk,
   input  logic       resetn,
   input  logic       clear,
   input  logic       en,
   input  logic       din,
   output logic [6:0] crc
);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         crc <= '0;
      end else if (clear) begin
         crc <= '0;
      end else if (en) begin
         crc <= crc7_next(crc, din);
      end
   end

endmodule

// File: rtl/sd_card_cmd_responder.sv
// Card-side CMD line model: decodes host commands, tracks the
// identification-mode state and serialises R1/R2/R3/R6/R7 replies.
module sd_card_cmd_responder
   import sd_card_pkg::*;
#(
   parameter logic [15:0]  RCA         = 16'hF792,
   parameter logic [127:0] CID         = 128'h7E4456BFAFE53C7AB12900000ECDB3,
   parameter logic [31:0]  OCR         = 32'h00FF8000,
   parameter int           BUSY_POLLS  = 2,
   parameter int           NCR         = 2,
   parameter int           SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       sd_clk,
   input  logic       cmd_in,
   output logic       cmd_out,
   output logic       cmd_oe,
   output logic [3:0] card_state,
   output logic       cmd_valid,
   output logic [5:0] cmd_index,
   output logic       crc_err,
   output logic       illegal_cmd
);

   localparam int SM = SYNC_STAGES - 1;

   logic [SM:0]    clk_sync;
   logic [SM:0]    cmd_sync;
   logic           sclk_d;
   logic           tick;
   logic           fall;
   logic           cbit;

   fsm_t           state;
   card_state_t    cstate;
   resp_t          rsp;
   logic           got_start;
   logic           prev_bit;
   logic           app_cmd;
   logic [3:0]     busy_cnt;

   logic [5:0]     rx_cnt;
   logic [19:0]    rx_sr;
   logic [5:0]     rx_idx;
   logic [6:0]     rx_crc;
   logic           rx_clr;
   logic           rx_en;

   logic [135:0]   tx_sr;
   logic [7:0]     tx_len;
   logic [7:0]     tx_idx;
   logic [6:0]     wcnt;
   logic [6:0]     tx_crc;
   logic           tx_clr;
   logic           tx_en;
   logic           tx_bit;
   logic           use_crc;
   logic [2:0]     crc_pos;
   logic           first_fall;

   logic [31:0]    r1_status;
   logic [15:0]    r6_status;
   logic           ready_now;
   logic           frame_ok;

   assign tick = clk_sync[SM] & ~sclk_d;
   assign fall = ~clk_sync[SM] & sclk_d;
   assign cbit = cmd_sync[SM];

   assign card_state = cstate;

   assign rx_clr = (state == ST_IDLE) && !got_start;
   assign rx_en  = tick && (((state == ST_IDLE) && got_start) ||
                            ((state == ST_RX) && (rx_cnt < 6'd40)));

   assign use_crc = (rsp == RSP_R1) || (rsp == RSP_R6) || (rsp == RSP_R7);
   assign crc_pos = 3'd6 - tx_idx[2:0];
   assign tx_bit  = (use_crc && (tx_idx >= 8'd40) && (tx_idx < 8'd47))
                    ? tx_crc[crc_pos] : tx_sr[135];

   assign first_fall = fall && (state == ST_WAIT) && (wcnt == 7'(NCR));
   assign tx_clr = (state == ST_CHECK);
   assign tx_en  = first_fall ||
                   (fall && (state == ST_TX) && (tx_idx < 8'd40));

   assign r1_status = {19'd0, cstate, 9'h020};
   assign r6_status = {3'b000, cstate, 3'b000, app_cmd, 5'b00000};
   assign ready_now = busy_cnt >= 4'(BUSY_POLLS);
   assign frame_ok  = (rx_crc == rx_sr[7:1]) && rx_sr[0];

   sd_crc7_serial u_rx_crc (
      .clk    (clk),
      .resetn (resetn),
      .clear  (rx_clr),
      .en     (rx_en),
      .din    (cbit),
      .crc    (rx_crc)
   );

   sd_crc7_serial u_tx_crc (
      .clk    (clk),
      .resetn (resetn),
      .clear  (tx_clr),
      .en     (tx_en),
      .din    (tx_bit),
      .crc    (tx_crc)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         clk_sync    <= '0;
         cmd_sync    <= '0;
         sclk_d      <= 1'b0;
         state       <= ST_IDLE;
         cstate      <= CS_IDLE;
         rsp         <= RSP_NONE;
         got_start   <= 1'b0;
         prev_bit    <= 1'b0;
         app_cmd     <= 1'b0;
         busy_cnt    <= '0;
         rx_cnt      <= '0;
         rx_sr       <= '0;
         rx_idx      <= '0;
         tx_sr       <= '0;
         tx_len      <= LEN_SHORT;
         tx_idx      <= '0;
         wcnt        <= '0;
         cmd_out     <= 1'b1;
         cmd_oe      <= 1'b0;
         cmd_valid   <= 1'b0;
         cmd_index   <= '0;
         crc_err     <= 1'b0;
         illegal_cmd <= 1'b0;
      end else begin
         clk_sync    <= {clk_sync[SM-1:0], sd_clk};
         cmd_sync    <= {cmd_sync[SM-1:0], cmd_in};
         sclk_d      <= clk_sync[SM];
         cmd_valid   <= 1'b0;
         crc_err     <= 1'b0;
         illegal_cmd <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (tick) begin
                  prev_bit <= cbit;
                  if (got_start) begin
                     got_start <= 1'b0;
                     if (cbit) begin
                        state  <= ST_RX;
                        rx_cnt <= 6'd2;
                     end
                  end else if (prev_bit && !cbit) begin
                     got_start <= 1'b1;
                  end
               end
            end
            ST_RX: begin
               if (tick) begin
                  rx_sr  <= {rx_sr[18:0], cbit};
                  rx_cnt <= rx_cnt + 6'd1;
                  if (rx_cnt == 6'd7) rx_idx <= {rx_sr[4:0], cbit};
                  if (rx_cnt == 6'd47) state <= ST_CHECK;
               end
            end
            ST_CHECK: begin
               cmd_valid <= 1'b1;
               cmd_index <= rx_idx;
               prev_bit  <= rx_sr[0];
               rsp       <= RSP_NONE;
               tx_len    <= LEN_SHORT;
               tx_idx    <= '0;
               wcnt      <= '0;
               state     <= ST_IDLE;
               if (!frame_ok) begin
                  crc_err <= 1'b1;
               end else begin
                  app_cmd <= 1'b0;
                  unique case (1'b1)
                     rx_idx == CMD_GO_IDLE: begin
                        cstate   <= CS_IDLE;
                        busy_cnt <= '0;
                     end
                     rx_idx == CMD_IF_COND: begin
                        rsp   <= RSP_R7;
                        tx_sr <= {2'b00, CMD_IF_COND, 20'd0, rx_sr[19:8],
                                  8'h01, 88'd0};
                        state <= ST_WAIT;
                     end
                     rx_idx == CMD_APP: begin
                        app_cmd <= 1'b1;
                        rsp     <= RSP_R1;
                        tx_sr   <= {2'b00, CMD_APP, r1_status, 8'h01, 88'd0};
                        state   <= ST_WAIT;
                     end
                     (rx_idx == CMD_SD_OP_COND) && app_cmd: begin
                        rsp   <= RSP_R3;
                        tx_sr <= {2'b00, 6'h3F, ready_now, OCR[30:0],
                                  8'hFF, 88'd0};
                        state <= ST_WAIT;
                        if (busy_cnt != 4'd15) busy_cnt <= busy_cnt + 4'd1;
                        if (ready_now) cstate <= CS_READY;
                     end
                     (rx_idx == CMD_ALL_CID) && (cstate == CS_READY): begin
                        rsp    <= RSP_R2;
                        tx_sr  <= {2'b00, 6'h3F, CID[127:1], 1'b1};
                        tx_len <= LEN_LONG;
                        cstate <= CS_IDENT;
                        state  <= ST_WAIT;
                     end
                     (rx_idx == CMD_SEND_RCA) &&
                     ((cstate == CS_IDENT) || (cstate == CS_STBY)): begin
                        rsp    <= RSP_R6;
                        tx_sr  <= {2'b00, CMD_SEND_RCA, RCA, r6_status,
                                   8'h01, 88'd0};
                        cstate <= CS_STBY;
                        state  <= ST_WAIT;
                     end
                     default: begin
                        illegal_cmd <= 1'b1;
                     end
                  endcase
               end
            end
            ST_WAIT: begin
               if (first_fall) begin
                  cmd_oe  <= 1'b1;
                  cmd_out <= tx_bit;
                  tx_sr   <= {tx_sr[134:0], 1'b0};
                  tx_idx  <= 8'd1;
                  state   <= ST_TX;
               end else if (fall) begin
                  wcnt <= wcnt + 7'd1;
               end
            end
            ST_TX: begin
               if (fall) begin
                  if (tx_idx < tx_len) begin
                     cmd_out <= tx_bit;
                     tx_sr   <= {tx_sr[134:0], 1'b0};
                     tx_idx  <= tx_idx + 8'd1;
                  end else if (tx_idx == tx_len) begin
                     cmd_out <= 1'b1;
                     tx_idx  <= tx_idx + 8'd1;
                  end else begin
                     // Host must show a fresh idle 1 before the next start bit.
                     cmd_oe    <= 1'b0;
                     cmd_out   <= 1'b1;
                     prev_bit  <= 1'b0;
                     got_start <= 1'b0;
                     state     <= ST_IDLE;
                  end
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sd_card_cmd_responder.sv
// Directed host-side bench for sd_card_cmd_responder.
module tb_sd_card_cmd_responder;

   localparam logic [15:0]  RCA = 16'hF792;
   localparam logic [127:0] CID = 128'h7E4456BFAFE53C7AB12900000ECDB3;
   localparam logic [31:0]  OCR = 32'h00FF8000;

   logic       clk = 1'b0;
   logic       resetn;
   logic       sd_clk;
   logic       cmd_in;
   logic       cmd_out;
   logic       cmd_oe;
   logic [3:0] card_state;
   logic       cmd_valid;
   logic [5:0] cmd_index;
   logic       crc_err;
   logic       illegal_cmd;

   int checks = 0;
   int fails  = 0;
   int n_valid = 0;
   int n_crc = 0;
   int n_ill = 0;

   sd_card_cmd_responder #(
      .RCA         (RCA),
      .CID         (CID),
      .OCR         (OCR),
      .BUSY_POLLS  (2),
      .NCR         (2),
      .SYNC_STAGES (2)
   ) dut (
      .clk         (clk),
      .resetn      (resetn),
      .sd_clk      (sd_clk),
      .cmd_in      (cmd_in),
      .cmd_out     (cmd_out),
      .cmd_oe      (cmd_oe),
      .card_state  (card_state),
      .cmd_valid   (cmd_valid),
      .cmd_index   (cmd_index),
      .crc_err     (crc_err),
      .illegal_cmd (illegal_cmd)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (cmd_valid) n_valid++;
      if (crc_err) n_crc++;
      if (illegal_cmd) n_ill++;
   end

   task automatic check(input string tag, input logic [135:0] obs,
                        input logic [135:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Long-division CRC7: message times x^7 modulo x^7+x^3+1.
   function automatic logic [6:0] crc7m(input logic [39:0] m);
      logic [7:0] t;
      logic [6:0] r;
      r = '0;
      for (int i = 39; i >= 0; i--) begin
         t = {r, m[i]};
         if (t[7]) t = t ^ 8'h89;
         r = t[6:0];
      end
      for (int i = 0; i < 7; i++) begin
         t = {r, 1'b0};
         if (t[7]) t = t ^ 8'h89;
         r = t[6:0];
      end
      return r;
   endfunction

   function automatic logic [47:0] mkcmd(input logic [5:0] idx,
                                         input logic [31:0] arg);
      logic [39:0] h;
      h = {2'b01, idx, arg};
      return {h, crc7m(h), 1'b1};
   endfunction

   function automatic logic [47:0] mkresp(input logic [39:0] h);
      return {h, crc7m(h), 1'b1};
   endfunction

   task automatic sd_bit(input logic b, output logic oe, output logic d);
      sd_clk = 1'b0;
      cmd_in = b;
      #40;
      oe = cmd_oe;
      d  = cmd_out;
      sd_clk = 1'b1;
      #40;
   endtask

   task automatic idle(input int n);
      logic oe, d;
      for (int i = 0; i < n; i++) sd_bit(1'b1, oe, d);
   endtask

   task automatic send(input logic [47:0] f);
      logic oe, d;
      for (int i = 47; i >= 0; i--) sd_bit(f[i], oe, d);
   endtask

   task automatic quiet(input int n, output int seen);
      logic oe, d;
      seen = 0;
      for (int i = 0; i < n; i++) begin
         sd_bit(1'b1, oe, d);
         if (oe) seen++;
      end
   endtask

   task automatic get_resp(input int len, output int gap,
                           output logic [135:0] r);
      logic oe, d;
      gap = 0;
      r   = '0;
      oe  = 1'b0;
      while (!oe && gap < 40) begin
         sd_bit(1'b1, oe, d);
         if (!oe) gap++;
      end
      if (oe) begin
         r[len-1] = d;
         for (int i = len - 2; i >= 0; i--) begin
            sd_bit(1'b1, oe, d);
            r[i] = d;
         end
      end
   endtask

   initial begin
      int gap, seen, v0, c0, i0;
      logic [135:0] r;
      logic [135:0] r2_exp;
      logic [3:0] st;
      logic b31;

      r2_exp = {2'b00, 6'h3F, CID[127:1], 1'b1};
      resetn = 1'b0;
      sd_clk = 1'b1;
      cmd_in = 1'b1;
      #20;
      check("rst_oe", 136'(cmd_oe), 136'(1'b0));
      check("rst_out", 136'(cmd_out), 136'(1'b1));
      check("rst_state", 136'(card_state), 136'(4'd0));
      check("rst_index", 136'(cmd_index), 136'(6'd0));
      check("rst_valid", 136'(cmd_valid), 136'(1'b0));
      #20;
      resetn = 1'b1;
      idle(4);

      v0 = n_valid;
      c0 = n_crc;
      send(48'h40_00000000_95);
      quiet(100, seen);
      check("cmd0_no_oe", 136'(seen), 136'(0));
      check("cmd0_valid", 136'(n_valid - v0), 136'(1));
      check("cmd0_crc_ok", 136'(n_crc - c0), 136'(0));
      check("cmd0_index", 136'(cmd_index), 136'(6'd0));
      check("cmd0_state", 136'(card_state), 136'(4'd0));

      c0 = n_crc;
      send(48'h48_000001AA_87);
      get_resp(48, gap, r);
      check("cmd8_ncr", 136'(gap), 136'(2));
      check("cmd8_r7", r, 136'(mkresp(40'h08_000001AA)));
      check("cmd8_crc_ok", 136'(n_crc - c0), 136'(0));
      check("cmd8_index", 136'(cmd_index), 136'(6'd8));
      idle(2);
      check("cmd8_release", 136'(cmd_oe), 136'(1'b0));

      c0 = n_crc;
      send(48'h48_000001AA_86);
      quiet(20, seen);
      check("badcrc_no_oe", 136'(seen), 136'(0));
      check("badcrc_pulse", 136'(n_crc - c0), 136'(1));
      check("badcrc_state", 136'(card_state), 136'(4'd0));

      for (int k = 0; k < 3; k++) begin
         st = 4'd0;
         send(mkcmd(6'd55, 32'h0));
         get_resp(48, gap, r);
         check("cmd55_r1", r,
               136'(mkresp({2'b00, 6'd55, 19'd0, st, 9'h020})));
         idle(2);
         send(mkcmd(6'd41, 32'h40FF8000));
         get_resp(48, gap, r);
         b31 = (k == 2);
         check("acmd41_busy", 136'(r[39]), 136'(b31));
         check("acmd41_r3", r,
               136'({2'b00, 6'h3F, b31, OCR[30:0], 7'h7F, 1'b1}));
         idle(2);
      end
      check("ready_state", 136'(card_state), 136'(4'd1));

      i0 = n_ill;
      send(mkcmd(6'd3, 32'h0));
      quiet(20, seen);
      check("cmd3_early_no_oe", 136'(seen), 136'(0));
      check("cmd3_early_illegal", 136'(n_ill - i0), 136'(1));
      check("cmd3_early_state", 136'(card_state), 136'(4'd1));

      send(mkcmd(6'd2, 32'h0));
      get_resp(136, gap, r);
      check("cmd2_ncr", 136'(gap), 136'(2));
      check("cmd2_r2", r, r2_exp);
      idle(2);
      check("cmd2_state", 136'(card_state), 136'(4'd2));

      send(mkcmd(6'd3, 32'h0));
      get_resp(48, gap, r);
      check("cmd3_r6", r,
            136'(mkresp({2'b00, 6'd3, RCA, 16'h0400})));
      idle(2);
      check("cmd3_state", 136'(card_state), 136'(4'd3));

      send(48'h40_00000000_95);
      idle(4);
      for (int k = 0; k < 3; k++) begin
         send(mkcmd(6'd55, 32'h0));
         get_resp(48, gap, r);
         idle(2);
         send(mkcmd(6'd41, 32'h40FF8000));
         get_resp(48, gap, r);
         idle(2);
      end
      check("ready_again", 136'(card_state), 136'(4'd1));
      send(mkcmd(6'd2, 32'h0));
      get_resp(40, gap, r);
      check("r2_head", r, 136'(r2_exp[135:96]));
      check("r2_midtx_oe", 136'(cmd_oe), 136'(1'b1));
      resetn = 1'b0;
      #3;
      check("rst_mid_oe", 136'(cmd_oe), 136'(1'b0));
      check("rst_mid_state", 136'(card_state), 136'(4'd0));
      #17;
      resetn = 1'b1;
      idle(4);

      v0 = n_valid;
      send(48'h40_00000000_95);
      quiet(20, seen);
      check("post_rst_cmd0_valid", 136'(n_valid - v0), 136'(1));
      check("post_rst_cmd0_no_oe", 136'(seen), 136'(0));
      send(48'h48_000001AA_87);
      get_resp(48, gap, r);
      check("post_rst_cmd8", r, 136'(mkresp(40'h08_000001AA)));
      idle(2);

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule
